// File: rtl/dpa_pkg.sv
// Shared definitions for the image-memory (IM) datapath blocks: bus widths,
// frame geometries and the scan-out state encoding.
package dpa_pkg;

    localparam int IM_ADDR_W = 20;
    localparam int IM_DATA_W = 24;

    localparam int GEOM_128 = 128;
    localparam int GEOM_256 = 256;
    localparam int GEOM_512 = 512;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_REQ_ENC   = 2'd1;
    localparam logic [1:0] ST_FETCH_ENC = 2'd2;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_REQ   = ST_REQ_ENC,
        S_FETCH = ST_FETCH_ENC,
        S_DRAIN = ST_DRAIN_ENC
    } scan_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered-pointer design; a push and a pop in
// the same cycle leave the occupancy unchanged.
module sync_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    // NOTE: storage has no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: reads a whole frame from IM through a prefetch FIFO and
// emits it as a valid/ready pixel stream with frame and line markers.
module fb_scanout
    import dpa_pkg::*;
#(
    parameter int ADDR_W     = IM_ADDR_W,
    parameter int DATA_W     = IM_DATA_W,
    parameter int LINE_W     = GEOM_256,
    parameter int N_LINES    = GEOM_256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] im_a,
    output logic              im_wen_n,
    input  logic [DATA_W-1:0] im_q,
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_sof,
    output logic              px_sol,
    output logic              px_eof,
    output logic              busy,
    output logic              done
);

    localparam int NPIX  = LINE_W * N_LINES;
    localparam int IDX_W = $clog2(NPIX);
    localparam int COL_W = $clog2(LINE_W);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [ADDR_W-1:0] im_a_q;
    logic              inflight_q;
    logic              done_q, done_d;

    logic              issue;
    logic              pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (im_q),
        .pop_i       (pop),
        .head_o      (px_data),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    // Reads in flight count against FIFO space so a returning word always fits.
    assign issue = (state_q == S_FETCH) && bus_gnt
                && ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));

    // The address goes out in the issue cycle; the SRAM returns data one cycle later.
    assign im_a     = issue ? (base_q + ADDR_W'(rd_idx_q)) : im_a_q;
    assign im_wen_n = 1'b1;

    assign px_valid = !fifo_empty;
    assign pop      = px_valid && px_ready;
    assign px_sof   = px_valid && (out_idx_q == '0);
    assign px_sol   = px_valid && (out_idx_q[COL_W-1:0] == '0);
    assign px_eof   = px_valid && (out_idx_q == LAST_IDX);

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        rd_idx_d  = rd_idx_q;
        out_idx_d = pop ? (out_idx_q + IDX_W'(1)) : out_idx_q;
        done_d    = 1'b0;
        bus_req   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d    = fb_base;
                    rd_idx_d  = '0;
                    out_idx_d = '0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) state_d = S_FETCH;
            end
            S_FETCH: begin
                bus_req = 1'b1;
                if (issue) begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                    if (rd_idx_q == LAST_IDX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (out_idx_q == LAST_IDX)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            rd_idx_q   <= '0;
            out_idx_q  <= '0;
            im_a_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rd_idx_q   <= rd_idx_d;
            out_idx_q  <= out_idx_d;
            im_a_q     <= im_a;
            inflight_q <= issue;
            done_q     <= done_d;
        end
    end

endmodule
